// File: rtl/pll_lock_seq_pkg.sv
// Shared types for the PLL lock sequencer: lock FSM state encoding.
package pll_lock_seq_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        StWaitLock = 2'd0,
        StStable   = 2'd1,
        StRun      = 2'd2
    } state_e;

endpackage

// File: rtl/clk_en_div.sv
// Per-channel clock-enable divider: counts 0..D-1 and pulses tick on the last count.
module clk_en_div #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             run_i,
    input  logic             en_i,
    input  logic             realign_i,
    input  logic [CNT_W-1:0] div_i,
    output logic             tick_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic [CNT_W-1:0] div_eff;
    logic [CNT_W-1:0] period;
    logic             last;

    always_comb begin
        div_eff = (div_i == '0) ? CNT_W'(1) : div_i;
        // A period's length is fixed by the divide ratio seen at its count-0 cycle.
        period   = (cnt_q == '0) ? div_eff : shadow_q;
        shadow_d = period;
        last     = (cnt_q == period - CNT_W'(1));
        tick_o   = run_i & en_i & last & ~realign_i;
        if (!run_i || !en_i || realign_i || last) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            shadow_q <= CNT_W'(1);
        end else begin
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
        end
    end

endmodule

// File: rtl/pll_lock_seq.sv
// PLL lock qualifier: synchronises raw lock, debounces it, releases reset and gates
// phase-aligned per-channel clock enables; records lock losses seen while running.
module pll_lock_seq
    import pll_lock_seq_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned LOCK_STABLE = 1024,
    parameter int unsigned LOSS_W      = 8
) (
    input  logic                    refclk,
    input  logic                    rst,
    input  logic                    pll_locked,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic [NUM_CH*CNT_W-1:0] div,
    input  logic                    realign,
    input  logic                    loss_clr,
    output logic [NUM_CH-1:0]       tick,
    output logic                    locked,
    output logic                    rst_out,
    output logic                    lost_sticky,
    output logic [LOSS_W-1:0]       loss_cnt
);

    localparam int unsigned SW = (LOCK_STABLE > 1) ? $clog2(LOCK_STABLE) : 1;

    logic [1:0]        sync_q;
    logic              lk_s;
    state_e            state_q, state_d;
    logic [SW-1:0]     stable_q, stable_d;
    logic              locked_q, locked_d;
    logic              rst_out_q, rst_out_d;
    logic              lost_q, lost_d;
    logic [LOSS_W-1:0] loss_cnt_q, loss_cnt_d;
    logic              loss_evt;
    logic              run;

    assign lk_s = sync_q[1];
    assign run  = (state_q == StRun);

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q   <= StWaitLock;
            stable_q  <= '0;
            locked_q  <= 1'b0;
            rst_out_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            stable_q  <= stable_d;
            locked_q  <= locked_d;
            rst_out_q <= rst_out_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        stable_d = stable_q;
        case (state_q)
            StWaitLock: begin
                if (lk_s) begin
                    state_d  = StStable;
                    stable_d = '0;
                end
            end
            StStable: begin
                if (!lk_s) begin
                    state_d = StWaitLock;
                end else if (stable_q == SW'(LOCK_STABLE - 1)) begin
                    state_d = StRun;
                end else begin
                    stable_d = stable_q + SW'(1);
                end
            end
            StRun: begin
                if (!lk_s) begin
                    state_d = StWaitLock;
                end
            end
            default: state_d = StWaitLock;
        endcase
    end

    always_comb begin
        locked_d   = (state_d == StRun);
        rst_out_d  = ~locked_d;
        loss_evt   = run & ~lk_s;
        lost_d     = lost_q;
        loss_cnt_d = loss_cnt_q;
        if (loss_clr) begin
            lost_d     = 1'b0;
            loss_cnt_d = '0;
        end
        // A loss in the same cycle as a clear is still recorded after the clear.
        if (loss_evt) begin
            lost_d = 1'b1;
            if (loss_cnt_d != '1) begin
                loss_cnt_d = loss_cnt_d + LOSS_W'(1);
            end
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync_q     <= 2'b00;
            lost_q     <= 1'b0;
            loss_cnt_q <= '0;
        end else begin
            sync_q     <= {sync_q[0], pll_locked};
            lost_q     <= lost_d;
            loss_cnt_q <= loss_cnt_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_en_div #(
            .CNT_W(CNT_W)
        ) u_div (
            .clk_i    (refclk),
            .rst_i    (rst),
            .run_i    (run),
            .en_i     (ch_en[i]),
            .realign_i(realign),
            .div_i    (div[i*CNT_W +: CNT_W]),
            .tick_o   (tick[i])
        );
    end

    assign locked      = locked_q;
    assign rst_out     = rst_out_q;
    assign lost_sticky = lost_q;
    assign loss_cnt    = loss_cnt_q;

endmodule

// File: tb/tb_pll_lock_seq.sv
// Bench for pll_lock_seq: directed lock/tick/loss scenarios plus random traffic,
// all checked each cycle against a streak-based behavioural model.
module tb_pll_lock_seq;

    localparam int unsigned NUM_CH      = 4;
    localparam int unsigned CNT_W       = 8;
    localparam int unsigned LOCK_STABLE = 16;
    localparam int unsigned LOSS_W      = 8;
    localparam int          LOSS_MAX    = (1 << LOSS_W) - 1;

    logic                    refclk;
    logic                    rst;
    logic                    pll_locked;
    logic [NUM_CH-1:0]       ch_en;
    logic [NUM_CH*CNT_W-1:0] div;
    logic                    realign;
    logic                    loss_clr;
    logic [NUM_CH-1:0]       tick;
    logic                    locked;
    logic                    rst_out;
    logic                    lost_sticky;
    logic [LOSS_W-1:0]       loss_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    pll_lock_seq #(
        .NUM_CH     (NUM_CH),
        .CNT_W      (CNT_W),
        .LOCK_STABLE(LOCK_STABLE),
        .LOSS_W     (LOSS_W)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .ch_en      (ch_en),
        .div        (div),
        .realign    (realign),
        .loss_clr   (loss_clr),
        .tick       (tick),
        .locked     (locked),
        .rst_out    (rst_out),
        .lost_sticky(lost_sticky),
        .loss_cnt   (loss_cnt)
    );

    initial begin
        refclk = 1'b0;
        forever #5 refclk = ~refclk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic check_near(input string name, input int act, input int exp, input int tol);
        n_checks++;
        if (act >= exp - tol && act <= exp + tol) n_pass++;
        else $display("FAIL %s: got %0d expected %0d+-%0d", name, act, exp, tol);
    endtask

    // Behavioural model: RUN means lk_s has been seen high on LOCK_STABLE+1
    // consecutive edges; each channel tracks its place in the current period.
    bit pipe0 = 0, pipe1 = 0;
    int streak = 0;
    bit m_sticky = 0;
    int m_lcnt = 0;
    int pos[NUM_CH];
    int per[NUM_CH];

    function automatic bit m_run();
        return streak >= int'(LOCK_STABLE) + 1;
    endfunction

    function automatic int div_of(input int ch);
        int v;
        v = int'((div >> (ch * CNT_W)) & {{(NUM_CH*CNT_W-CNT_W){1'b0}}, {CNT_W{1'b1}}});
        return (v == 0) ? 1 : v;
    endfunction

    function automatic int period_of(input int ch);
        return (pos[ch] == 0) ? div_of(ch) : per[ch];
    endfunction

    function automatic logic [NUM_CH-1:0] exp_tick();
        logic [NUM_CH-1:0] t;
        for (int i = 0; i < NUM_CH; i++)
            t[i] = m_run() && ch_en[i] && !realign && (pos[i] == period_of(i) - 1);
        return t;
    endfunction

    always @(posedge refclk or posedge rst) begin
        if (rst) begin
            pipe0 = 0; pipe1 = 0; streak = 0; m_sticky = 0; m_lcnt = 0;
            for (int i = 0; i < NUM_CH; i++) begin pos[i] = 0; per[i] = 1; end
        end else begin
            bit ls, was_run;
            ls = pipe1; pipe1 = pipe0; pipe0 = pll_locked;
            was_run = m_run();
            for (int i = 0; i < NUM_CH; i++) begin
                int d;
                d = period_of(i);
                per[i] = d;
                if (!was_run || !ch_en[i] || realign || pos[i] == d - 1) pos[i] = 0;
                else pos[i] = pos[i] + 1;
            end
            if (loss_clr) begin m_sticky = 0; m_lcnt = 0; end
            if (was_run && !ls) begin
                m_sticky = 1;
                if (m_lcnt < LOSS_MAX) m_lcnt++;
            end
            if (ls) begin if (streak <= int'(LOCK_STABLE)) streak++; end
            else streak = 0;
        end
    end

    always @(negedge refclk) begin
        check("m_tick", tick, exp_tick());
        check("m_locked", locked, m_run());
        check("m_rst_out", rst_out, !m_run());
        check("m_lost_sticky", lost_sticky, m_sticky);
        check("m_loss_cnt", loss_cnt, m_lcnt);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic wait_fall(input int budget, output int n);
        n = 0;
        while (rst_out && n < budget) begin
            @(posedge refclk); #1;
            n++;
        end
    endtask

    initial begin
        int n;
        rst = 1'b1; pll_locked = 1'b0; ch_en = '1; realign = 1'b0; loss_clr = 1'b0;
        div = {8'd0, 8'd1, 8'd3, 8'd4};
        repeat (3) @(posedge refclk);
        #1;
        check("rst_rst_out", rst_out, 1);
        check("rst_locked", locked, 0);
        check("rst_tick", tick, 0);
        check("rst_loss_cnt", loss_cnt, 0);
        rst = 1'b0;

        // lock acquisition latency
        repeat (10) @(posedge refclk);
        #1 pll_locked = 1'b1;
        wait_fall(40, n);
        check_near("lock_latency", n, 19, 1);
        check("lock_locked", locked, 1);

        // tick pattern with div={0,1,3,4}, ch0 ratio changed 4->2 mid-period
        for (int c = 0; c < 20; c++) begin
            bit e0, e1;
            if (c == 13) div[0 +: CNT_W] = 8'd2;
            #1;
            e0 = (c == 3 || c == 7 || c == 11 || c == 15 || c == 17 || c == 19);
            e1 = (c % 3 == 2);
            check("tick_pattern", tick, {1'b1, 1'b1, e1, e0});
            @(posedge refclk); #1;
        end

        // lock loss during RUN
        pll_locked = 1'b0;
        repeat (2) @(posedge refclk);
        #1 check("loss_still_run", locked, 1);
        @(posedge refclk); #1;
        check("loss_tick", tick, 0);
        check("loss_rst_out", rst_out, 1);
        check("loss_sticky", lost_sticky, 1);
        check("loss_cnt1", loss_cnt, 1);

        loss_clr = 1'b1;
        @(posedge refclk); #1 loss_clr = 1'b0;
        check("clr_sticky", lost_sticky, 0);
        check("clr_cnt", loss_cnt, 0);

        // one-cycle dropout while STABLE restarts the full count
        pll_locked = 1'b1;
        repeat (11) @(posedge refclk);
        #1 pll_locked = 1'b0;
        @(posedge refclk); #1 pll_locked = 1'b1;
        wait_fall(40, n);
        check_near("restart_latency", n, 19, 1);
        check("restart_sticky", lost_sticky, 0);

        // repeated losses saturate the counter
        for (int r = 0; r < 300; r++) begin
            pll_locked = 1'b0;
            repeat (4) @(posedge refclk);
            #1 pll_locked = 1'b1;
            wait_fall(40, n);
            check("relock", locked, 1);
        end
        check("sat_cnt", loss_cnt, 255);
        check("sat_sticky", lost_sticky, 1);

        // clear coincident with a loss event
        pll_locked = 1'b0;
        repeat (2) @(posedge refclk);
        #1 loss_clr = 1'b1;
        @(posedge refclk); #1 loss_clr = 1'b0;
        check("clr_coll_cnt", loss_cnt, 1);
        check("clr_coll_sticky", lost_sticky, 1);
        pll_locked = 1'b1;

        // random traffic
        for (int k = 0; k < 3000; k++) begin
            if (pll_locked ? ($urandom_range(79) == 0) : ($urandom_range(29) == 0))
                pll_locked = ~pll_locked;
            realign  = ($urandom_range(7) == 0);
            loss_clr = ($urandom_range(31) == 0);
            if ($urandom_range(15) == 0) ch_en = NUM_CH'($urandom);
            if ($urandom_range(4) == 0)
                div[$urandom_range(NUM_CH - 1) * CNT_W +: CNT_W] = CNT_W'($urandom_range(6));
            @(posedge refclk); #1;
        end
        realign = 1'b0; loss_clr = 1'b0; ch_en = '1;

        // asynchronous reset in RUN with a nonzero loss count
        pll_locked = 1'b1;
        wait_fall(60, n);
        pll_locked = 1'b0;
        repeat (4) @(posedge refclk);
        #1 pll_locked = 1'b1;
        wait_fall(40, n);
        check("pre_reset_run", locked, 1);
        check("pre_reset_loss", loss_cnt != 0, 1);
        #1 rst = 1'b1;
        #1;
        check("arst_tick", tick, 0);
        check("arst_locked", locked, 0);
        check("arst_rst_out", rst_out, 1);
        check("arst_sticky", lost_sticky, 0);
        check("arst_loss_cnt", loss_cnt, 0);
        @(posedge refclk); #1 rst = 1'b0;
        repeat (3) @(posedge refclk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pll_lock_seq.md
PLL_LOCK_SEQ -- requirements
Module: pll_lock_seq

Interface
REQ-001 Parameter NUM_CH, default 4, number of clock-enable channels (1..8) SHALL be supported.
REQ-002 Parameter CNT_W, default 16, SHALL set divider width per channel.
REQ-003 Parameter LOCK_STABLE, default 1024, SHALL set cycles of continuous lock required before release (>=2).
REQ-004 Parameter LOSS_W, default 8, SHALL set lock-loss counter width.
REQ-005 refclk  in  1  sole clock; all logic rising-edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 pll_locked  in  1  raw PLL lock, asynchronous to refclk.
REQ-008 ch_en  in  NUM_CH  per-channel enable mask.
REQ-009 div  in  NUM_CH*CNT_W  per-channel divide ratio, channel i at bits [i*CNT_W +: CNT_W].
REQ-010 realign  in  1  single-cycle pulse; phase-realigns all channel counters.
REQ-011 loss_clr  in  1  clears lost_sticky and loss_cnt.
REQ-012 tick  out  NUM_CH  one-cycle clock-enable pulses.
REQ-013 locked  out  1  qualified lock (high only in RUN).
REQ-014 rst_out  out  1  synchronous active-high downstream reset.
REQ-015 lost_sticky  out  1  set on any lock loss during RUN.
REQ-016 loss_cnt  out  LOSS_W  saturating count of RUN lock losses.

Function
REQ-017 pll_locked SHALL pass through a 2-flop synchroniser (lk_s); no other logic SHALL sample it directly.
REQ-018 FSM states: WAIT_LOCK, STABLE, RUN.
REQ-019 WAIT_LOCK: lk_s=1 -> STABLE with stable counter cleared to 0.
REQ-020 STABLE: lk_s=0 -> WAIT_LOCK; counter reaching LOCK_STABLE-1 with lk_s=1 -> RUN; else counter increments.
REQ-021 RUN: lk_s=0 -> WAIT_LOCK, same cycle set lost_sticky and increment loss_cnt (saturate at all-ones).
REQ-022 rst_out SHALL be a registered output, 1 in WAIT_LOCK/STABLE, 0 in RUN; locked = (state==RUN), registered identically.
REQ-023 Latency: pll_locked rising held stable -> rst_out falls 2+LOCK_STABLE+1 cycles later (+-1 for sync metastability).
REQ-024 Each channel counter counts 0..D-1 where D=max(div_i,1); tick_i=1 when counter==D-1, state==RUN and ch_en_i=1; counter then wraps to 0.
REQ-025 div_i SHALL be sampled into a shadow register only at wrap or when counter is 0; mid-period changes take effect next period.
REQ-026 div_i of 0 or 1 SHALL yield tick_i high every RUN cycle.
REQ-027 ch_en_i=0: counter held at 0, tick_i=0; re-enable starts a fresh period from 0.
REQ-028 On entry to RUN and on realign, all counters SHALL clear to 0 simultaneously (phase-aligned); realign in the same cycle as a wrap wins (no tick that cycle).
REQ-029 Outside RUN all tick bits SHALL be 0 and counters held at 0.
REQ-030 loss_clr SHALL clear lost_sticky and loss_cnt; simultaneous loss event and loss_clr: clear wins, then loss_cnt=1, lost_sticky=1 (event recorded).

Reset
REQ-031 rst asserted SHALL asynchronously force: state=WAIT_LOCK, synchroniser=0, counters=0, shadows=1, tick=0, locked=0, rst_out=1, lost_sticky=0, loss_cnt=0.
REQ-032 rst asserted mid-RUN SHALL not count as lock loss.

Structure
REQ-033 Package pll_lock_seq_pkg SHALL hold the state enum and state-encoding width constant.
REQ-034 Per-channel divider SHALL be sub-module clk_en_div (counter, shadow, tick), instantiated NUM_CH times by generate.

Verification
REQ-035 LOCK_STABLE=16: raise pll_locked at cycle 10 -> rst_out falls and locked rises at cycle 29 (+-1).
REQ-036 pll_locked dropped for 1 cycle during STABLE at count 10 -> returns to WAIT_LOCK, full 16-cycle count restarts, lost_sticky stays 0.
REQ-037 RUN, div={4,3,1,0}, ch_en=4'b1111 -> ticks ch0 every 4th, ch1 every 3rd, ch2/ch3 every cycle; ch0/ch1 first tick at RUN cycle 3/2, simultaneous at cycle 11.
REQ-038 RUN, change div0 4->2 at counter=1 -> next ch0 tick still at counter 3, then period 2.
REQ-039 RUN, drop pll_locked -> 3 cycles later ticks=0, rst_out=1, lost_sticky=1, loss_cnt=1; repeat 300 times with LOSS_W=8 -> loss_cnt=255.
REQ-040 Assert rst in RUN -> all outputs at reset values without a clock edge; loss_cnt=0.
